// File: rtl/light_show_pkg.sv
// Shared definitions for the light pattern sequencer: mode encodings,
// default widths, sparkle LFSR seed/taps and the LFSR next-state helper.
package light_show_pkg;

  typedef enum logic [1:0] {
    MODE_CHASE   = 2'd0,
    MODE_BOUNCE  = 2'd1,
    MODE_BAR     = 2'd2,
    MODE_SPARKLE = 2'd3
  } mode_e;

  localparam int unsigned RED_W_DEF = 10;
  localparam int unsigned GRN_W_DEF = 8;

  // x^10 + x^7 + 1, shifting toward the MSB, feedback into bit 0
  localparam int unsigned         LFSR_W        = 10;
  localparam logic [LFSR_W-1:0]   LFSR_SEED_DEF = 10'h2A5;
  localparam int unsigned         LFSR_TAP_HI   = 9;
  localparam int unsigned         LFSR_TAP_LO   = 6;

  // Next LFSR state; a stuck all-zero state recovers to the seed
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] seed);
    if (s == '0) return seed;
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/light_lfsr.sv
// Sparkle pattern generator: 10-bit Fibonacci LFSR with reload to seed.
module light_lfsr
  import light_show_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              adv_i,
  input  logic              reload_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  // Next state: reload wins over advance, otherwise hold
  always_comb begin
    state_d = state_q;
    if (reload_i)   state_d = SEED;
    else if (adv_i) state_d = lfsr_next(state_q, SEED);
  end

  // State register with synchronous active-low reset to the seed
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= SEED;
    else         state_q <= state_d;
  end

  assign state_o = state_q;

endmodule

// File: rtl/light_pattern_seq.sv
// Tick-stepped LED pattern sequencer: chase, bounce, bar and sparkle
// patterns on the red LEDs, completed-cycle counter on the green LEDs.
module light_pattern_seq
  import light_show_pkg::*;
#(
  parameter int unsigned       RED_W     = RED_W_DEF,
  parameter int unsigned       GRN_W     = GRN_W_DEF,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             Tick,
  input  logic [1:0]       Mode,
  input  logic             Pause,
  input  logic             Dir,
  output logic [RED_W-1:0] LedRed,
  output logic [GRN_W-1:0] LedGrn,
  output logic             CycleDone
);

  localparam int unsigned        POS_W     = (RED_W > 1) ? $clog2(RED_W) : 1;
  localparam int unsigned        FILL_W    = $clog2(RED_W + 1);
  localparam logic [POS_W-1:0]   POS_LAST  = POS_W'(RED_W - 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(RED_W);

  mode_e              mode_q, mode_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic               up_q, up_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               filling_q, filling_d;
  logic [RED_W-1:0]   red_q, red_d;
  logic [GRN_W-1:0]   grn_q, grn_d;
  logic               done_q, done_d;

  logic               step, wrap;
  logic               lfsr_adv, lfsr_reload;
  logic [LFSR_W-1:0]  lfsr_state, lfsr_nxt;

  light_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i    (Clock),
    .rst_ni   (ResetN),
    .adv_i    (lfsr_adv),
    .reload_i (lfsr_reload),
    .state_o  (lfsr_state)
  );

  // Next-state and next-output logic; LED image is rendered from the
  // post-step state so outputs track a step with one register stage
  always_comb begin
    mode_d      = mode_q;
    pos_d       = pos_q;
    up_d        = up_q;
    fill_d      = fill_q;
    filling_d   = filling_q;
    red_d       = red_q;
    grn_d       = grn_q;
    done_d      = 1'b0;
    wrap        = 1'b0;
    lfsr_adv    = 1'b0;
    lfsr_reload = 1'b0;
    lfsr_nxt    = lfsr_next(lfsr_state, LFSR_SEED);
    step        = Tick && !Pause;

    if (step) begin
      if (mode_e'(Mode) != mode_q) begin
        mode_d = mode_e'(Mode);
        unique case (mode_d)
          MODE_CHASE, MODE_BOUNCE: begin
            pos_d = '0;
            up_d  = 1'b1;
          end
          MODE_BAR: begin
            fill_d    = '0;
            filling_d = 1'b1;
          end
          MODE_SPARKLE: lfsr_reload = 1'b1;
        endcase
      end else begin
        unique case (mode_q)
          MODE_CHASE: begin
            if (!Dir) begin
              if (pos_q == POS_LAST) begin
                pos_d = '0;
                wrap  = 1'b1;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = POS_LAST;
                wrap  = 1'b1;
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
          MODE_BOUNCE: begin
            if (up_q) begin
              if (pos_q == POS_LAST) begin
                pos_d = POS_LAST - POS_W'(1);
                up_d  = 1'b0;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                pos_d = POS_W'(1);
                up_d  = 1'b1;
              end else begin
                pos_d = pos_q - POS_W'(1);
                wrap  = (pos_q == POS_W'(1));
              end
            end
          end
          MODE_BAR: begin
            if (filling_q) begin
              fill_d = fill_q + FILL_W'(1);
              if (fill_d == FILL_FULL) filling_d = 1'b0;
            end else begin
              fill_d = fill_q - FILL_W'(1);
              if (fill_d == '0) begin
                filling_d = 1'b1;
                wrap      = 1'b1;
              end
            end
          end
          MODE_SPARKLE: begin
            lfsr_adv = 1'b1;
            wrap     = (lfsr_nxt == LFSR_SEED);
          end
        endcase
      end

      if (wrap) begin
        done_d = 1'b1;
        grn_d  = grn_q + GRN_W'(1);
      end

      unique case (mode_d)
        MODE_CHASE, MODE_BOUNCE: red_d = RED_W'(1) << pos_d;
        MODE_BAR: begin
          for (int unsigned i = 0; i < RED_W; i++) begin
            red_d[i] = Dir ? (i + 32'(fill_d) >= RED_W) : (i < 32'(fill_d));
          end
        end
        MODE_SPARKLE: red_d = RED_W'(lfsr_reload ? LFSR_SEED : lfsr_nxt);
      endcase
    end
  end

  // Sequencer state and registered outputs, synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      mode_q    <= MODE_CHASE;
      pos_q     <= '0;
      up_q      <= 1'b1;
      fill_q    <= '0;
      filling_q <= 1'b1;
      red_q     <= RED_W'(1);
      grn_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      pos_q     <= pos_d;
      up_q      <= up_d;
      fill_q    <= fill_d;
      filling_q <= filling_d;
      red_q     <= red_d;
      grn_q     <= grn_d;
      done_q    <= done_d;
    end
  end

  assign LedRed    = red_q;
  assign LedGrn    = grn_q;
  assign CycleDone = done_q;

endmodule

// File: tb/tb_light_pattern_seq.sv
// Self-checking bench for light_pattern_seq: vector table plus
// hand-written long-run sequences, checked through a scoreboard queue.
module tb_light_pattern_seq;

  logic       clk;
  logic       ResetN, Tick, Pause, Dir;
  logic [1:0] Mode;
  logic [9:0] LedRed;
  logic [7:0] LedGrn;
  logic       CycleDone;

  typedef struct {
    logic       rn;
    logic       tk;
    logic       ps;
    logic [1:0] md;
    logic       dr;
    logic [9:0] er;
    logic [7:0] eg;
    logic       ed;
    string      nm;
  } vec_t;

  typedef struct {
    logic [9:0] er;
    logic [7:0] eg;
    logic       ed;
    string      nm;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   done_seen = 0;

  light_pattern_seq #(
    .RED_W     (10),
    .GRN_W     (8),
    .LFSR_SEED (10'h2A5)
  ) dut (
    .Clock     (clk),
    .ResetN    (ResetN),
    .Tick      (Tick),
    .Mode      (Mode),
    .Pause     (Pause),
    .Dir       (Dir),
    .LedRed    (LedRed),
    .LedGrn    (LedGrn),
    .CycleDone (CycleDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs; when chk is set, push the expectation and
  // compare it against the outputs just after the active edge
  task automatic apply(input logic rn, input logic tk, input logic ps,
                       input logic [1:0] md, input logic dr, input bit chk,
                       input logic [9:0] er, input logic [7:0] eg,
                       input logic ed, input string nm);
    exp_t e;
    @(negedge clk);
    ResetN = rn; Tick = tk; Pause = ps; Mode = md; Dir = dr;
    if (chk) sb.push_back('{er, eg, ed, nm});
    @(posedge clk);
    #1;
    if (CycleDone === 1'b1) done_seen++;
    if (chk) begin
      e = sb.pop_front();
      cmp({e.nm, ".red"},  32'(LedRed),    32'(e.er));
      cmp({e.nm, ".grn"},  32'(LedGrn),    32'(e.eg));
      cmp({e.nm, ".done"}, 32'(CycleDone), 32'(e.ed));
    end
  endtask

  initial begin
    logic [9:0] er;
    ResetN = 1'b0; Tick = 1'b0; Pause = 1'b0; Mode = 2'd0; Dir = 1'b0;

    // rn tk ps md dr   red      grn  done
    vecs.push_back('{0, 1, 1, 0, 0, 10'h001, 8'd0, 0, "reset"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h002, 8'd0, 0, "chase1"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h004, 8'd0, 0, "chase2"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h008, 8'd0, 0, "chase3"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h010, 8'd0, 0, "chase4"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h020, 8'd0, 0, "chase5"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h040, 8'd0, 0, "chase6"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h080, 8'd0, 0, "chase7"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h100, 8'd0, 0, "chase8"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h200, 8'd0, 0, "chase9"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h001, 8'd1, 1, "chase_wrap"});
    vecs.push_back('{1, 1, 1, 0, 0, 10'h001, 8'd1, 0, "pause"});
    vecs.push_back('{1, 0, 0, 0, 0, 10'h001, 8'd1, 0, "no_tick"});
    vecs.push_back('{1, 1, 0, 0, 1, 10'h200, 8'd2, 1, "chase_dn_wrap"});
    vecs.push_back('{1, 1, 0, 0, 1, 10'h100, 8'd2, 0, "chase_dn"});
    vecs.push_back('{1, 1, 0, 0, 0, 10'h200, 8'd2, 0, "dir_flip"});
    vecs.push_back('{1, 1, 0, 2, 0, 10'h000, 8'd2, 0, "to_bar"});
    vecs.push_back('{1, 1, 0, 2, 1, 10'h200, 8'd2, 0, "bar_hi1"});
    vecs.push_back('{1, 1, 0, 2, 1, 10'h300, 8'd2, 0, "bar_hi2"});
    vecs.push_back('{1, 1, 0, 2, 1, 10'h380, 8'd2, 0, "bar_hi3"});
    vecs.push_back('{1, 1, 0, 2, 0, 10'h00F, 8'd2, 0, "bar_lo4"});
    vecs.push_back('{1, 1, 1, 3, 0, 10'h00F, 8'd2, 0, "pause_vs_mode"});
    vecs.push_back('{1, 0, 0, 3, 0, 10'h00F, 8'd2, 0, "mode_no_tick"});
    vecs.push_back('{1, 1, 0, 3, 0, 10'h2A5, 8'd2, 0, "to_sparkle"});
    vecs.push_back('{1, 1, 0, 3, 0, 10'h14B, 8'd2, 0, "sparkle1"});

    foreach (vecs[i])
      apply(vecs[i].rn, vecs[i].tk, vecs[i].ps, vecs[i].md, vecs[i].dr, 1'b1,
            vecs[i].er, vecs[i].eg, vecs[i].ed, vecs[i].nm);

    // Bounce: full period of 18 steps, then reset coincident with step 12
    apply(0, 1, 0, 1, 0, 1, 10'h001, 8'd0, 0, "b_reset");
    apply(1, 1, 0, 1, 0, 1, 10'h001, 8'd0, 0, "b_enter");
    for (int k = 1; k <= 18; k++) begin
      er = 10'h001;
      er = (k <= 9) ? (er << k) : (er << (18 - k));
      apply(1, 1, 0, 1, 0, 1, er, 8'((k == 18) ? 1 : 0), (k == 18),
            $sformatf("bounce%0d", k));
    end
    apply(0, 1, 0, 1, 0, 1, 10'h001, 8'd0, 0, "b_reset2");
    apply(1, 1, 0, 1, 0, 1, 10'h001, 8'd0, 0, "b_enter2");
    for (int k = 1; k <= 11; k++) apply(1, 1, 0, 1, 0, 0, '0, '0, 0, "");
    apply(0, 1, 0, 1, 0, 1, 10'h001, 8'd0, 0, "b_mid_reset");
    apply(1, 1, 0, 0, 0, 1, 10'h002, 8'd0, 0, "mode_after_reset");

    // Bar, Dir=0: fill up over 10 steps, drain over 10 more
    apply(0, 1, 0, 2, 0, 1, 10'h001, 8'd0, 0, "bar_reset");
    apply(1, 1, 0, 2, 0, 1, 10'h000, 8'd0, 0, "bar_enter");
    for (int k = 1; k <= 20; k++) begin
      er = 10'((k <= 10) ? ((1 << k) - 1) : ((1 << (20 - k)) - 1));
      apply(1, 1, 0, 2, 0, 1, er, 8'((k == 20) ? 1 : 0), (k == 20),
            $sformatf("bar%0d", k));
    end

    // Sparkle: full LFSR period back to the seed
    apply(0, 1, 0, 3, 0, 1, 10'h001, 8'd0, 0, "sp_reset");
    apply(1, 1, 0, 3, 0, 1, 10'h2A5, 8'd0, 0, "sp_enter");
    apply(1, 1, 0, 3, 0, 1, 10'h14B, 8'd0, 0, "sp_step1");
    done_seen = 0;
    for (int k = 2; k <= 1022; k++) apply(1, 1, 0, 3, 0, 0, '0, '0, 0, "");
    cmp("sp_early_done", 32'(done_seen), 32'd0);
    apply(1, 1, 0, 3, 0, 1, 10'h2A5, 8'd1, 1, "sp_period");

    // Green counter wraps after 256 chase cycles
    apply(0, 1, 0, 0, 0, 1, 10'h001, 8'd0, 0, "g_reset");
    for (int k = 1; k <= 2549; k++) apply(1, 1, 0, 0, 0, 0, '0, '0, 0, "");
    apply(1, 1, 0, 0, 0, 1, 10'h001, 8'd255, 1, "grn_255");
    for (int k = 1; k <= 9; k++) apply(1, 1, 0, 0, 0, 0, '0, '0, 0, "");
    apply(1, 1, 0, 0, 0, 1, 10'h001, 8'd0, 1, "grn_wrap");

    cmp("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/light_pattern_seq.md
LIGHT_PATTERN_SEQ -- requirements
Module: light_pattern_seq

Interface
REQ-001 Parameter RED_W, default 10: number of red LED outputs (pattern width).
REQ-002 Parameter GRN_W, default 8: width of the green LED completed-cycle counter.
REQ-003 Parameter LFSR_SEED, default 10'h2A5: sparkle LFSR reset/reload value; SHALL be nonzero.
REQ-004 Clock  in  1: single system clock (50 MHz onboard); all state SHALL change on its rising edge only.
REQ-005 ResetN  in  1: synchronous, active-low reset.
REQ-006 Tick  in  1: one-Clock-cycle step pulse from the upstream variable-frequency divider (lights pulse).
REQ-007 Mode  in  2: pattern select from switches: 0 chase, 1 bounce, 2 bar, 3 sparkle.
REQ-008 Pause  in  1: 1 freezes the pattern.
REQ-009 Dir  in  1: 0 = toward higher LED index, 1 = toward lower; used only by chase and bar.
REQ-010 LedRed  out  RED_W: pattern; 1 = lit.
REQ-011 LedGrn  out  GRN_W: count of completed pattern cycles.
REQ-012 CycleDone  out  1: one-cycle pulse on the edge where a pattern cycle completes.

Function
REQ-013 Step event = rising edge with ResetN=1, Tick=1, Pause=0; without a step event, no state SHALL change.
REQ-014 Mode SHALL be sampled only on step events; if it differs from the held ModeReg: load ModeReg, enter the new mode's initial state, no pattern advance, no CycleDone, LedGrn unchanged.
REQ-015 Chase: position Pos 0..RED_W-1, LedRed = one-hot at Pos; initial Pos=0; Dir=0 increments with wrap RED_W-1->0, Dir=1 decrements with wrap 0->RED_W-1; either wrap SHALL complete a cycle.
REQ-016 Bounce: one-hot Pos with internal BounceUp flag, initial Pos=0, BounceUp=1; at Pos=RED_W-1 moving up, next Pos=RED_W-2 and BounceUp=0; at Pos=0 moving down, next Pos=1 and BounceUp=1; arrival at Pos=0 completes a cycle (period 2*(RED_W-1) steps).
REQ-017 Bar: Fill 0..RED_W, internal Filling flag, initial Fill=0, Filling=1; Fill increments to RED_W, then decrements to 0; arrival at 0 completes a cycle (period 2*RED_W steps).
REQ-018 Bar output: Dir=0 lights bits [Fill-1:0]; Dir=1 lights the top Fill bits; Fill=0 gives all-off.
REQ-019 Sparkle: 10-bit Fibonacci LFSR, polynomial x^10+x^7+1, shifting toward the MSB with feedback into bit 0; LedRed = LFSR state; initial state LFSR_SEED; an all-zero state SHALL reload LFSR_SEED; return to LFSR_SEED completes a cycle (period 1023).
REQ-020 On cycle completion: CycleDone=1 for exactly that cycle; LedGrn increments modulo 2^GRN_W (wraps 255->0).
REQ-021 Latency: LedRed/LedGrn/CycleDone SHALL reflect a step event immediately after the rising edge on which it occurs (one register stage, no further delay).
REQ-022 Priority: ResetN low > Pause > mode change > pattern advance.
REQ-023 A Dir change SHALL take effect on the next step event without resetting Pos or Fill.

Reset
REQ-024 On a rising edge with ResetN=0: ModeReg=0, Pos=0, BounceUp=1, Fill=0, Filling=1, LFSR=LFSR_SEED, LedRed=10'h001, LedGrn=0, CycleDone=0, regardless of Tick or Pause.
REQ-025 Reset asserted mid-pattern SHALL abandon the cycle without a CycleDone pulse.

Structure
REQ-026 Shared package light_show_pkg SHALL hold the MODE_CHASE/MODE_BOUNCE/MODE_BAR/MODE_SPARKLE constants, the RED_W/GRN_W defaults, the LFSR seed, and the tap positions.
REQ-027 The LFSR SHALL be a sub-module light_lfsr (inputs: clock, reset, advance enable, reload; output: state); all other logic stays in light_pattern_seq.

Verification
REQ-028 Reset; Mode=0, Dir=0; 3 steps -> LedRed 10'h002, 10'h004, 10'h008; LedGrn=0.
REQ-029 Chase, Dir=0, 10 steps from reset -> LedRed=10'h001, single CycleDone pulse, LedGrn=1; Dir=1 from reset, 1 step -> LedRed=10'h200 with CycleDone.
REQ-030 Bounce: step 9 -> 10'h200; step 10 -> 10'h100; step 18 -> 10'h001 with CycleDone, LedGrn=1.
REQ-031 Bar, Dir=0: step 10 -> 10'h3FF; step 20 -> 10'h000 with CycleDone; with Dir=1 instead, step 3 -> 10'h380.
REQ-032 Tick with Pause=1 -> no change; Mode 0->2 with Tick -> LedRed=10'h000, LedGrn unchanged, no CycleDone; sparkle for 1023 steps -> LedRed=10'h2A5 with CycleDone.
REQ-033 ResetN=0 coincident with Tick at bounce step 12 -> LedRed=10'h001, LedGrn=0, CycleDone=0 after that edge.
